// File: rtl/key_event_decoder_pkg.sv
// Shared types and default timing constants for the key event decoder, its hold timer,
// the debouncer and the board top level.
package key_event_decoder_pkg;

    typedef enum logic [1:0] {
        WaitLow  = 2'd0,
        Idle     = 2'd1,
        Pressed  = 2'd2,
        LongHeld = 2'd3
    } key_state_e;

    localparam int unsigned DefLongTicks   = 50_000_000;
    localparam int unsigned DefRepeatTicks = 10_000_000;
    localparam int unsigned DefCntW        = 26;

    function automatic logic state_is_held(key_state_e s);
        return (s == Pressed) || (s == LongHeld);
    endfunction

endpackage

// File: rtl/key_event_decoder_hold_timer.sv
// Hold-duration counter: synchronous clear has priority over enable; at_tc flags the
// current count equal to the supplied terminal value.
module key_hold_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic             at_tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_tc = (cnt == tc_val);

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into registered one-cycle press/release/click/long/repeat
// pulses plus a held level.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = DefLongTicks,
    parameter int unsigned REPEAT_TICKS = DefRepeatTicks,
    parameter int unsigned CNT_W        = DefCntW
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LongTc   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatTc = CNT_W'(REPEAT_TICKS - 1);
    localparam bit               RepeatOn = (REPEAT_TICKS != 0);

    key_state_e       state_q, state_d;
    logic             press_d, release_d, click_d, long_d, repeat_d;
    logic             cnt_clr, cnt_en, at_tc;
    logic [CNT_W-1:0] tc_val;

    // One counter serves both thresholds; the compare value follows the state.
    assign tc_val = (state_q == LongHeld) ? RepeatTc : LongTc;

    key_hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (tc_val),
        .at_tc  (at_tc)
    );

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            WaitLow: begin
                if (!signal_in) state_d = Idle;
            end
            Idle: begin
                if (signal_in) begin
                    press_d = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = Pressed;
                end
            end
            Pressed: begin
                // Release is tested first so it wins over a coincident threshold.
                if (!signal_in) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    state_d   = Idle;
                end else if (at_tc) begin
                    long_d  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = LongHeld;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LongHeld: begin
                if (!signal_in) begin
                    release_d = 1'b1;
                    state_d   = Idle;
                end else if (RepeatOn && at_tc) begin
                    repeat_d = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (RepeatOn) begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = WaitLow;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WaitLow;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state_q       <= state_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            click_pulse   <= click_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
        end
    end

    assign held = state_is_held(state_q);

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: one instance with repeats enabled, one with repeats disabled,
// both compared every cycle against a hold-age model of the key events.
module tb_key_event_decoder;

    localparam int LT = 8;
    localparam int RT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sig_a = 1'b0, sig_b = 1'b0;
    logic press_a, rel_a, click_a, long_a, rep_a, held_a;
    logic press_b, rel_b, click_b, long_b, rep_b, held_b;

    int checks = 0;
    int errors = 0;

    // Model: armed once a low level is seen, then hold age counted in edges since the press.
    bit         arm [2];
    bit         prs [2];
    int         age [2];
    logic [5:0] expv [2];

    always #5 clk = ~clk;

    key_event_decoder #(.LONG_TICKS(LT), .REPEAT_TICKS(RT), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .signal_in(sig_a),
        .press_pulse(press_a), .release_pulse(rel_a), .click_pulse(click_a),
        .long_pulse(long_a), .repeat_pulse(rep_a), .held(held_a)
    );

    key_event_decoder #(.LONG_TICKS(LT), .REPEAT_TICKS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .signal_in(sig_b),
        .press_pulse(press_b), .release_pulse(rel_b), .click_pulse(click_b),
        .long_pulse(long_b), .repeat_pulse(rep_b), .held(held_b)
    );

    // Bit order: {press, release, click, long, repeat, held}
    function automatic logic [5:0] obs(input int k);
        if (k == 0) return {press_a, rel_a, click_a, long_a, rep_a, held_a};
        return {press_b, rel_b, click_b, long_b, rep_b, held_b};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            arm[k] = 1'b0; prs[k] = 1'b0; age[k] = 0; expv[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input logic s, input int rt);
        logic [5:0] e;
        e = '0;
        if (!arm[k]) begin
            if (!s) arm[k] = 1'b1;
        end else if (!prs[k]) begin
            if (s) begin
                prs[k] = 1'b1; age[k] = 0; e[5] = 1'b1;
            end
        end else begin
            age[k]++;
            if (!s) begin
                prs[k] = 1'b0; e[4] = 1'b1; e[3] = (age[k] <= LT);
            end else begin
                e[2] = (age[k] == LT);
                e[1] = (rt != 0) && (age[k] > LT) && (((age[k] - LT) % rt) == 0);
            end
        end
        e[0] = prs[k];
        expv[k] = e;
    endtask

    task automatic tick(input logic a, input logic b);
        sig_a = a;
        sig_b = b;
        @(posedge clk);
        model_step(0, a, RT);
        model_step(1, b, 0);
        #1;
    endtask

    task automatic test_reset();
        sig_a = 1'b1; sig_b = 1'b1;
        #1 rst = 1'b1;
        #3;
        checks++;
        if ({obs(0), obs(1)} !== 12'b0) begin
            errors++; $display("FAIL reset_async got %b want 0", {obs(0), obs(1)});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({obs(0), obs(1)} !== 12'b0) begin
            errors++; $display("FAIL reset_held got %b want 0", {obs(0), obs(1)});
        end
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({obs(0), obs(1)} !== {expv[0], expv[1]}) begin
                errors++; $display("FAIL reset_hold cyc %0d got %b want %b", i,
                                   {obs(0), obs(1)}, {expv[0], expv[1]});
            end
        end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if ({press_a, held_a, press_b, held_b} !== 4'b1111) begin
            errors++; $display("FAIL reset_first_press got %b want 1111",
                               {press_a, held_a, press_b, held_b});
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_click();
        int held_cnt = 0, click_cnt = 0, long_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(i < 4, i < 4);
            checks++;
            if ({obs(0), obs(1)} !== {expv[0], expv[1]}) begin
                errors++; $display("FAIL click_model cyc %0d got %b want %b", i,
                                   {obs(0), obs(1)}, {expv[0], expv[1]});
            end
            held_cnt  += int'(held_a);
            click_cnt += int'(click_a && rel_a && i == 4);
            long_cnt  += int'(long_a);
        end
        checks++;
        if (held_cnt !== 4 || click_cnt !== 1 || long_cnt !== 0) begin
            errors++; $display("FAIL click_counts held %0d click %0d long %0d want 4 1 0",
                               held_cnt, click_cnt, long_cnt);
        end
    endtask

    task automatic test_long_repeat();
        int long_idx = -1, rep_n = 0, rep_idx [2];
        rep_idx[0] = -1; rep_idx[1] = -1;
        for (int i = 0; i < 16; i++) begin
            tick(i < 15, i < 15);
            checks++;
            if ({obs(0), obs(1)} !== {expv[0], expv[1]}) begin
                errors++; $display("FAIL long_model cyc %0d got %b want %b", i,
                                   {obs(0), obs(1)}, {expv[0], expv[1]});
            end
            if (long_a) long_idx = i;
            if (rep_a) begin
                if (rep_n < 2) rep_idx[rep_n] = i;
                rep_n++;
            end
        end
        checks++;
        if (long_idx !== LT || rep_n !== 2 || rep_idx[0] !== LT + RT || rep_idx[1] !== LT + 2 * RT)
        begin
            errors++; $display("FAIL long_timing long %0d reps %0d at %0d %0d want 8 2 11 14",
                               long_idx, rep_n, rep_idx[0], rep_idx[1]);
        end
        checks++;
        if ({rel_a, click_a} !== 2'b10) begin
            errors++; $display("FAIL long_release got %b want 10", {rel_a, click_a});
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_exact_threshold();
        int long_cnt = 0;
        for (int i = 0; i <= LT; i++) begin
            tick(i < LT, i < LT);
            checks++;
            if ({obs(0), obs(1)} !== {expv[0], expv[1]}) begin
                errors++; $display("FAIL thresh_model cyc %0d got %b want %b", i,
                                   {obs(0), obs(1)}, {expv[0], expv[1]});
            end
            long_cnt += int'(long_a);
        end
        checks++;
        if (obs(0) !== 6'b011000 || long_cnt !== 0) begin
            errors++; $display("FAIL thresh_release got %b long %0d want 011000 0",
                               obs(0), long_cnt);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_no_repeat();
        int long_cnt = 0, rep_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            tick(i < 30, i < 30);
            checks++;
            if ({obs(0), obs(1)} !== {expv[0], expv[1]}) begin
                errors++; $display("FAIL norep_model cyc %0d got %b want %b", i,
                                   {obs(0), obs(1)}, {expv[0], expv[1]});
            end
            long_cnt += int'(long_b);
            rep_cnt  += int'(rep_b);
        end
        checks++;
        if (long_cnt !== 1 || rep_cnt !== 0) begin
            errors++; $display("FAIL norep_counts long %0d repeat %0d want 1 0",
                               long_cnt, rep_cnt);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_midhold();
        for (int i = 0; i < 11; i++) tick(1'b1, 1'b1);
        checks++;
        if ({held_a, held_b} !== 2'b11) begin
            errors++; $display("FAIL midhold_pre got %b want 11", {held_a, held_b});
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({obs(0), obs(1)} !== 12'b0) begin
            errors++; $display("FAIL midhold_async got %b want 0", {obs(0), obs(1)});
        end
        model_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) begin
            tick(i != 5, i != 5);
            checks++;
            if ({obs(0), obs(1)} !== {expv[0], expv[1]}) begin
                errors++; $display("FAIL midhold_model cyc %0d got %b want %b", i,
                                   {obs(0), obs(1)}, {expv[0], expv[1]});
            end
            if (i < 5) begin
                checks++;
                if ({obs(0), obs(1)} !== 12'b0) begin
                    errors++; $display("FAIL midhold_quiet cyc %0d got %b want 0", i,
                                       {obs(0), obs(1)});
                end
            end
        end
        checks++;
        if ({press_a, press_b} !== 2'b11) begin
            errors++; $display("FAIL midhold_repress got %b want 11", {press_a, press_b});
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic la = 1'b0, lb = 1'b0;
        int   na = 0, nb = 0;
        for (int i = 0; i < 600; i++) begin
            if (na == 0) begin la = ~la; na = int'($urandom_range(1, 18)); end
            if (nb == 0) begin lb = ~lb; nb = int'($urandom_range(1, 18)); end
            na--; nb--;
            tick(la, lb);
            checks++;
            if ({obs(0), obs(1)} !== {expv[0], expv[1]}) begin
                errors++; $display("FAIL random cyc %0d got %b want %b", i,
                                   {obs(0), obs(1)}, {expv[0], expv[1]});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_click();
        test_long_repeat();
        test_exact_threshold();
        test_no_repeat();
        test_reset_midhold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
